// File: rtl/red_centroid_tracker_pkg.sv
// Shared widths, FSM encoding and red-pixel qualification for the centroid tracker.
package red_centroid_tracker_pkg;

   localparam int COORD_W = 16;
   localparam int CNT_W   = 20;
   localparam int SUM_W   = COORD_W + CNT_W;

   localparam logic [7:0]       R_TH_DEF    = 8'd160;
   localparam logic [7:0]       MARGIN_DEF  = 8'd40;
   localparam logic [CNT_W-1:0] MIN_PIX_DEF = 20'd64;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_DIV_X = 2'd1;
   localparam logic [1:0] ST_DIV_Y = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // Margin sums are formed in 9 bits so G/B near 255 cannot wrap into a false hit.
   function automatic logic is_red(input logic       de,
                                   input logic       act,
                                   input logic [7:0] r,
                                   input logic [7:0] g,
                                   input logic [7:0] b,
                                   input logic [7:0] r_th,
                                   input logic [7:0] margin);
      logic [8:0] g_lim;
      logic [8:0] b_lim;
      g_lim = {1'b0, g} + {1'b0, margin};
      b_lim = {1'b0, b} + {1'b0, margin};
      return de & act & (r >= r_th) & ({1'b0, r} > g_lim) & ({1'b0, r} > b_lim);
   endfunction

endpackage

// File: rtl/red_centroid_tracker_divider.sv
// Restoring divider, one quotient bit per cycle MSB first; done pulses SUM_W cycles after start.
module seq_divider
   import red_centroid_tracker_pkg::*;
(
   input  logic               CLK,
   input  logic               RST,
   input  logic               start,
   input  logic [SUM_W-1:0]   dividend,
   input  logic [CNT_W-1:0]   divisor,
   output logic               done,
   output logic [COORD_W-1:0] quotient
);

   logic [CNT_W-1:0] div_q;
   logic [CNT_W-1:0] rem_q;
   logic [SUM_W-1:0] quo_q;
   logic [5:0]       iter_q;
   logic             run_q;

   logic [CNT_W-1:0] step_div;
   logic [CNT_W-1:0] step_rem_in;
   logic [SUM_W-1:0] step_quo_in;
   logic [CNT_W:0]   trial;
   logic [CNT_W:0]   diff;
   logic [CNT_W-1:0] step_rem;
   logic [SUM_W-1:0] step_quo;

   // The start cycle already performs the first iteration on the incoming operands.
   always_comb begin
      step_div    = start ? divisor  : div_q;
      step_rem_in = start ? '0       : rem_q;
      step_quo_in = start ? dividend : quo_q;
      trial       = {step_rem_in, step_quo_in[SUM_W-1]};
      diff        = trial - {1'b0, step_div};
      step_quo    = {step_quo_in[SUM_W-2:0], 1'b0};
      step_rem    = trial[CNT_W-1:0];
      if (trial >= {1'b0, step_div}) begin
         step_rem    = diff[CNT_W-1:0];
         step_quo[0] = 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         div_q  <= '0;
         rem_q  <= '0;
         quo_q  <= '0;
         iter_q <= '0;
         run_q  <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            div_q  <= divisor;
            rem_q  <= step_rem;
            quo_q  <= step_quo;
            iter_q <= 6'd1;
            run_q  <= 1'b1;
         end else if (run_q) begin
            rem_q  <= step_rem;
            quo_q  <= step_quo;
            iter_q <= iter_q + 6'd1;
            if (iter_q == 6'(SUM_W - 1)) begin
               run_q <= 1'b0;
               done  <= 1'b1;
            end
         end
      end
   end

   // Mean never exceeds the largest coordinate, so the low 16 bits are the whole result.
   assign quotient = quo_q[COORD_W-1:0];

endmodule

// File: rtl/red_centroid_tracker.sv
// Accumulates red-pixel coordinates per frame and publishes the centroid after each frame start.
module red_centroid_tracker
   import red_centroid_tracker_pkg::*;
#(
   parameter logic [7:0]       R_TH    = R_TH_DEF,
   parameter logic [7:0]       MARGIN  = MARGIN_DEF,
   parameter logic [CNT_W-1:0] MIN_PIX = MIN_PIX_DEF
)
(
   input  logic               CLK,
   input  logic               RST,
   input  logic               VS,
   input  logic               DE,
   input  logic               ACTIV_C,
   input  logic [15:0]        H_CNT,
   input  logic [15:0]        V_CNT,
   input  logic [7:0]         R,
   input  logic [7:0]         G,
   input  logic [7:0]         B,
   output logic [COORD_W-1:0] CEN_X,
   output logic [COORD_W-1:0] CEN_Y,
   output logic [CNT_W-1:0]   PIX_CNT,
   output logic               FOUND,
   output logic               VALID,
   output logic               BUSY,
   output logic               OVERRUN
);

   logic             red;
   logic             fs;
   logic             r_vs;
   logic             snap_go;
   logic [SUM_W-1:0] sum_x;
   logic [SUM_W-1:0] sum_y;
   logic [CNT_W-1:0] cnt;
   logic [SUM_W-1:0] snap_y;
   logic [1:0]       state;
   logic [COORD_W-1:0] quo_x;

   logic               div_start;
   logic               div_done;
   logic [SUM_W-1:0]   div_dividend;
   logic [CNT_W-1:0]   div_divisor;
   logic [COORD_W-1:0] div_quo;

   assign red     = is_red(DE, ACTIV_C, R, G, B, R_TH, MARGIN);
   assign fs      = VS & ~r_vs;
   assign snap_go = fs & (state == ST_IDLE) & (cnt >= MIN_PIX);
   assign BUSY    = (state != ST_IDLE);

   // One divider serves both axes: X starts from the live sums, Y from the snapshot.
   assign div_start    = snap_go | ((state == ST_DIV_X) & div_done);
   assign div_dividend = (state == ST_IDLE) ? sum_x : snap_y;
   assign div_divisor  = (state == ST_IDLE) ? cnt : PIX_CNT;

   seq_divider u_div (
      .CLK      (CLK),
      .RST      (RST),
      .start    (div_start),
      .dividend (div_dividend),
      .divisor  (div_divisor),
      .done     (div_done),
      .quotient (div_quo)
   );

   // The pixel on the frame-start cycle seeds the new frame rather than closing the old one.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_vs  <= 1'b0;
         sum_x <= '0;
         sum_y <= '0;
         cnt   <= '0;
      end else begin
         r_vs <= VS;
         if (fs) begin
            sum_x <= red ? {{(SUM_W-16){1'b0}}, H_CNT} : '0;
            sum_y <= red ? {{(SUM_W-16){1'b0}}, V_CNT} : '0;
            cnt   <= {{(CNT_W-1){1'b0}}, red};
         end else if (red && (cnt != '1)) begin
            sum_x <= sum_x + {{(SUM_W-16){1'b0}}, H_CNT};
            sum_y <= sum_y + {{(SUM_W-16){1'b0}}, V_CNT};
            cnt   <= cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= ST_IDLE;
         snap_y  <= '0;
         quo_x   <= '0;
         CEN_X   <= '0;
         CEN_Y   <= '0;
         PIX_CNT <= '0;
         FOUND   <= 1'b0;
         VALID   <= 1'b0;
         OVERRUN <= 1'b0;
      end else begin
         VALID <= 1'b0;
         if (fs && (state != ST_IDLE)) OVERRUN <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (fs) begin
                  PIX_CNT <= cnt;
                  snap_y  <= sum_y;
                  if (cnt >= MIN_PIX) begin
                     FOUND <= 1'b1;
                     state <= ST_DIV_X;
                  end else begin
                     FOUND <= 1'b0;
                     VALID <= 1'b1;
                  end
               end
            end
            ST_DIV_X: begin
               if (div_done) begin
                  quo_x <= div_quo;
                  state <= ST_DIV_Y;
               end
            end
            ST_DIV_Y: begin
               if (div_done) state <= ST_DONE;
            end
            default: begin
               CEN_X <= quo_x;
               CEN_Y <= div_quo;
               VALID <= 1'b1;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
